tlc_txn_checker: RTL
====================

// Module: tlc_txn_checker
// PURPOSE
// Protocol checker that sits beside the TL-C channel monitor and consumes the same handshakes (valid&ready per channel).
// It tracks each transaction from start to completion:
//   - A Acquire -> D Grant/GrantData -> E GrantAck;
//   - C Release/ReleaseData -> D ReleaseAck.
// It raises error pulses and counters for the test harness.
// Passive: it never drives any ready or valid signal.
// PARAMETERS
// SOURCE_W  6     source id width; the table has 2^SOURCE_W entries
// SINK_W    6     sink id width; the pending-GrantAck table has 2^SINK_W bits
// BEATS     2     data beats per block (64B over a 256-bit bus)
// TIMEOUT   4096  cycles without a D fire, while anything is outstanding, before a TIMEOUT error
// PORTS
// clock         in   1         clock
// reset         in   1         synchronous, active-high reset
// a_valid/a_ready   in  1/1    A handshake
// a_opcode      in   3         A opcode
// a_source      in   SOURCE_W  A source
// c_valid/c_ready   in  1/1    C handshake
// c_opcode      in   3         C opcode
// c_source      in   SOURCE_W  C source
// d_valid/d_ready   in  1/1    D handshake
// d_opcode      in   3         D opcode
// d_source      in   SOURCE_W  D source
// d_sink        in   SINK_W    D sink
// e_valid/e_ready   in  1/1    E handshake
// e_sink        in   SINK_W    E sink
// err_valid     out  1         one-cycle error pulse
// err_code      out  3         error code (see ERRORS)
// err_id        out  SOURCE_W  offending source or sink id
// err_count     out  16        saturating error count
// outstanding   out  SOURCE_W+1  number of non-IDLE source entries
// acq_done      out  32        completed Acquire count (wraps)
// BEHAVIOUR
// - Fire: X_fire = X_valid & X_ready. All state is updated on posedge clock.
// - Reset: all entries IDLE; all pending bits 0; all beat counters 0; every output 0.
//   Reset mid-burst discards all in-flight state.
// - Per-source entry states: IDLE, WAIT_GRANT, WAIT_RACK.
// - A fire, opcode 6 or 7:
//   - entry IDLE -> WAIT_GRANT;
//   - otherwise DUP_SOURCE, and the entry is left unchanged.
//   - Any other A opcode -> BAD_OPCODE.
// - C fire:
//   - opcode 6 (Release, 1 beat) or opcode 7 (ReleaseData, BEATS beats): IDLE -> WAIT_RACK on the first beat;
//     a non-IDLE entry gives DUP_SOURCE.
//   - opcode 5 (ProbeAckData, BEATS beats) and opcode 4 (ProbeAck, 1 beat) are beat-counted only.
// - D fire:
//   - opcode 4 (1 beat) or opcode 5 (BEATS beats): the entry must be WAIT_GRANT, else UNEXP_D.
//     On the last beat: entry -> IDLE, acq_done += 1, pending[d_sink] set.
//     If pending[d_sink] was already set, SINK_REUSE is raised and the bit stays set.
//   - opcode 6 ReleaseAck: the entry must be WAIT_RACK, else UNEXP_D; the entry -> IDLE.
// - E fire: pending[e_sink] must be set, else SPURIOUS_E; the bit is cleared.
// - Beat counters (C and D, separately): count from 0 to BEATS-1, then wrap to 0.
//   A mid-burst beat whose opcode or source differs from beat 0 -> BURST_BREAK.
//   The counter then restarts with this beat treated as beat 0.
// - Same-cycle ordering: apply D, then C, then A against the updated table.
//   So a D last beat and an A on the same source in one cycle is legal.
//   E is checked against the pending bits from before the cycle, so an E in the same cycle as its Grant is SPURIOUS_E.
// - Watchdog: counts cycles while outstanding>0 and no D fire.
//   Reaching TIMEOUT -> TIMEOUT error (err_id=0), and the counter is cleared.
//   The counter is also cleared on any D fire or when outstanding==0.
// - Errors are registered, so err_valid asserts 1 cycle after the offending fire.
//   If several errors occur in one cycle, the lowest code is reported; err_count adds 1 per cycle and saturates at 0xFFFF.
// - ERRORS: 1 DUP_SOURCE, 2 UNEXP_D, 3 SINK_REUSE, 4 SPURIOUS_E, 5 BURST_BREAK, 6 TIMEOUT, 7 BAD_OPCODE.
// - outstanding is registered and reflects the table after the current cycle's updates.
// TESTING
// - Legal Acquire flow: A AcquireBlock src=3; D GrantData src=3 sink=5 over 2 beats; E sink=5.
//   -> err_valid stays 0, acq_done=1, outstanding 1 -> 0.
// - Duplicate source: two AcquirePerm with src=7 and no D between them.
//   -> err_code=1, err_id=7, err_count=1, outstanding=1.
// - Release flow: C ReleaseData src=2 (2 beats); then D ReleaseAck src=2.
//   -> no error. A ReleaseAck src=9 with no matching C -> err_code=2, err_id=9.
// - Grant and E in the same cycle: E sink=4 in the same cycle as the Grant to sink=4 -> err_code=4.
//   The bit is then set; a later E sink=4 -> no error.
// - Burst break: GrantData beat0 src=1, then beat1 src=2.
//   -> err_code=5, err_id=2. Also: Acquire outstanding, D idle for 4096 cycles -> err_code=6.
// - Reset mid-burst: after GrantData beat0 only, assert reset.
//   -> outstanding=0, err_count=0. A new 2-beat GrantData after reset raises no BURST_BREAK.

Source files
------------

// File: rtl/tlc_txn_checker.sv
// TL-C transaction checker: tracks Acquire/Grant/GrantAck and Release/ReleaseAck per source, reports protocol errors.
// Latency: errors and counters are registered, visible 1 cycle after the offending handshake.
// Backpressure: purely passive observer, never drives ready or valid; it observes every fire.
module tlc_txn_checker #(
    parameter int SOURCE_W = 6,
    parameter int SINK_W   = 6,
    parameter int BEATS    = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    input  logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic                c_valid,
    input  logic                c_ready,
    input  logic [2:0]          c_opcode,
    input  logic [SOURCE_W-1:0] c_source,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic [SINK_W-1:0]   d_sink,
    input  logic                e_valid,
    input  logic                e_ready,
    input  logic [SINK_W-1:0]   e_sink,
    output logic                err_valid,
    output logic [2:0]          err_code,
    output logic [SOURCE_W-1:0] err_id,
    output logic [15:0]         err_count,
    output logic [SOURCE_W:0]   outstanding,
    output logic [31:0]         acq_done
);
    localparam int NUM_SRC  = 1 << SOURCE_W;
    localparam int NUM_SINK = 1 << SINK_W;
    localparam int BCW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WDW      = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [WDW-1:0] WD_LIMIT  = WDW'(TIMEOUT);

    typedef enum logic [1:0] {
        ENT_IDLE       = 2'd0,
        ENT_WAIT_GRANT = 2'd1,
        ENT_WAIT_RACK  = 2'd2
    } ent_e;

    ent_e                tbl_q [NUM_SRC];
    ent_e                tbl_d [NUM_SRC];
    logic [NUM_SINK-1:0] pend_q, pend_d;
    logic [BCW-1:0]      d_cnt_q, d_cnt_d, c_cnt_q, c_cnt_d;
    logic [2:0]          d_op_q, d_op_d, c_op_q, c_op_d;
    logic [SOURCE_W-1:0] d_src_q, d_src_d, c_src_q, c_src_d;
    logic [WDW-1:0]      wd_q, wd_d;
    logic                err_valid_q, err_valid_d;
    logic [2:0]          err_code_q, err_code_d;
    logic [SOURCE_W-1:0] err_id_q, err_id_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [SOURCE_W:0]   outstanding_q, outstanding_d;
    logic [31:0]         acq_done_q, acq_done_d;

    logic a_fire, c_fire, d_fire, e_fire;
    logic d_multi, c_multi, d_brk, c_brk, d_last, c_last, c_first;
    logic [BCW-1:0] d_idx, c_idx;
    logic [7:1] err_hit;
    logic [SOURCE_W-1:0] err_ids [1:7];

    assign a_fire  = a_valid & a_ready;
    assign c_fire  = c_valid & c_ready;
    assign d_fire  = d_valid & d_ready;
    assign e_fire  = e_valid & e_ready;
    // Data-carrying opcodes span BEATS beats; everything else is a single beat.
    assign d_multi = (d_opcode == 3'd5) || (d_opcode == 3'd1);
    assign c_multi = (c_opcode == 3'd5) || (c_opcode == 3'd7);

    // Beat tracking for C and D: a mismatching mid-burst beat breaks the burst and starts a new one.
    always_comb begin
        d_cnt_d = d_cnt_q;
        d_op_d  = d_op_q;
        d_src_d = d_src_q;
        d_brk   = 1'b0;
        d_idx   = d_cnt_q;
        d_last  = 1'b0;
        if (d_fire) begin
            if (d_cnt_q != '0 && (d_opcode != d_op_q || d_source != d_src_q)) begin
                d_brk = 1'b1;
                d_idx = '0;
            end
            if (d_idx == '0) begin
                d_op_d  = d_opcode;
                d_src_d = d_source;
            end
            d_last  = !d_multi || (d_idx == LAST_BEAT);
            d_cnt_d = d_last ? '0 : d_idx + 1'b1;
        end
        c_cnt_d = c_cnt_q;
        c_op_d  = c_op_q;
        c_src_d = c_src_q;
        c_brk   = 1'b0;
        c_idx   = c_cnt_q;
        c_last  = 1'b0;
        c_first = 1'b0;
        if (c_fire) begin
            if (c_cnt_q != '0 && (c_opcode != c_op_q || c_source != c_src_q)) begin
                c_brk = 1'b1;
                c_idx = '0;
            end
            if (c_idx == '0) begin
                c_op_d  = c_opcode;
                c_src_d = c_source;
            end
            c_first = (c_idx == '0);
            c_last  = !c_multi || (c_idx == LAST_BEAT);
            c_cnt_d = c_last ? '0 : c_idx + 1'b1;
        end
    end

    // Table update in D, C, A order; E checked against last cycle's pending bits; pick lowest error code.
    always_comb begin
        tbl_d         = tbl_q;
        pend_d        = pend_q;
        acq_done_d    = acq_done_q;
        outstanding_d = outstanding_q;
        wd_d          = wd_q;
        err_hit       = '0;
        for (int k = 1; k <= 7; k++) err_ids[k] = '0;

        if (d_fire || outstanding_q == '0) begin
            wd_d = '0;
        end else if (wd_q + 1'b1 == WD_LIMIT) begin
            wd_d       = '0;
            err_hit[6] = 1'b1;
        end else begin
            wd_d = wd_q + 1'b1;
        end

        if (e_fire) begin
            if (!pend_q[e_sink]) begin
                err_hit[4] = 1'b1;
                err_ids[4] = SOURCE_W'(e_sink);
            end
            pend_d[e_sink] = 1'b0;
        end

        if (d_fire) begin
            if (d_brk) begin
                err_hit[5] = 1'b1;
                err_ids[5] = d_source;
            end
            if (d_opcode == 3'd4 || d_opcode == 3'd5) begin
                if (tbl_d[d_source] != ENT_WAIT_GRANT) begin
                    err_hit[2] = 1'b1;
                    err_ids[2] = d_source;
                end else if (d_last) begin
                    tbl_d[d_source] = ENT_IDLE;
                    acq_done_d      = acq_done_d + 1'b1;
                    outstanding_d   = outstanding_d - 1'b1;
                    if (pend_q[d_sink]) begin
                        err_hit[3] = 1'b1;
                        err_ids[3] = SOURCE_W'(d_sink);
                    end
                    pend_d[d_sink] = 1'b1;
                end
            end else if (d_opcode == 3'd6) begin
                if (tbl_d[d_source] != ENT_WAIT_RACK) begin
                    err_hit[2] = 1'b1;
                    err_ids[2] = d_source;
                end else begin
                    tbl_d[d_source] = ENT_IDLE;
                    outstanding_d   = outstanding_d - 1'b1;
                end
            end
        end

        if (c_fire) begin
            if (c_brk && !err_hit[5]) begin
                err_hit[5] = 1'b1;
                err_ids[5] = c_source;
            end
            if (c_first && (c_opcode == 3'd6 || c_opcode == 3'd7)) begin
                if (tbl_d[c_source] == ENT_IDLE) begin
                    tbl_d[c_source] = ENT_WAIT_RACK;
                    outstanding_d   = outstanding_d + 1'b1;
                end else begin
                    err_hit[1] = 1'b1;
                    err_ids[1] = c_source;
                end
            end
        end

        if (a_fire) begin
            if (a_opcode == 3'd6 || a_opcode == 3'd7) begin
                if (tbl_d[a_source] == ENT_IDLE) begin
                    tbl_d[a_source] = ENT_WAIT_GRANT;
                    outstanding_d   = outstanding_d + 1'b1;
                end else if (!err_hit[1]) begin
                    err_hit[1] = 1'b1;
                    err_ids[1] = a_source;
                end
            end else begin
                err_hit[7] = 1'b1;
                err_ids[7] = a_source;
            end
        end

        err_valid_d = 1'b0;
        err_code_d  = '0;
        err_id_d    = '0;
        for (int k = 7; k >= 1; k--) begin
            if (err_hit[k]) begin
                err_valid_d = 1'b1;
                err_code_d  = 3'(k);
                err_id_d    = err_ids[k];
            end
        end
        err_count_d = err_count_q;
        if (err_valid_d && err_count_q != 16'hFFFF) err_count_d = err_count_q + 1'b1;
    end

    // State and registered outputs; reset discards all in-flight transactions and bursts.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) tbl_q[i] <= ENT_IDLE;
            pend_q        <= '0;
            d_cnt_q       <= '0;
            c_cnt_q       <= '0;
            d_op_q        <= '0;
            c_op_q        <= '0;
            d_src_q       <= '0;
            c_src_q       <= '0;
            wd_q          <= '0;
            err_valid_q   <= 1'b0;
            err_code_q    <= '0;
            err_id_q      <= '0;
            err_count_q   <= '0;
            outstanding_q <= '0;
            acq_done_q    <= '0;
        end else begin
            tbl_q         <= tbl_d;
            pend_q        <= pend_d;
            d_cnt_q       <= d_cnt_d;
            c_cnt_q       <= c_cnt_d;
            d_op_q        <= d_op_d;
            c_op_q        <= c_op_d;
            d_src_q       <= d_src_d;
            c_src_q       <= c_src_d;
            wd_q          <= wd_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
            err_id_q      <= err_id_d;
            err_count_q   <= err_count_d;
            outstanding_q <= outstanding_d;
            acq_done_q    <= acq_done_d;
        end
    end

    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign err_id      = err_id_q;
    assign err_count   = err_count_q;
    assign outstanding = outstanding_q;
    assign acq_done    = acq_done_q;
endmodule
